// File: rtl/add_sub_arbiter.sv
// rtl/add_sub_arbiter.sv - two-requester arbiter for a shared add/sub datapath
// Per-requester shadow accumulators; one command in flight; round-robin on contention.
module add_sub_arbiter #(
  parameter int WIDTH  = 8,
  parameter int DP_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,
  input  logic             req0_acc,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,
  input  logic             req1_acc,
  input  logic [1:0]       acc_clr,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_z,
  output logic             rsp_carry,
  output logic             rsp_ovf,
  output logic [WIDTH-1:0] dp_a,
  output logic [WIDTH-1:0] dp_b,
  output logic             dp_sel,
  output logic             dp_addsub,
  input  logic [WIDTH-1:0] dp_z,
  input  logic             dp_carry,
  input  logic             dp_ovf
);

  localparam int CW = (DP_LAT < 1) ? 1 : $clog2(DP_LAT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state, state_nxt;
  logic             prio;
  logic [WIDTH-1:0] shadow0, shadow1;
  logic [CW-1:0]    cnt;
  logic             gnt0, gnt1;
  logic             accept, rsp_hs;

  // On contention the priority pointer picks; otherwise the lone requester wins.
  always_comb begin
    gnt0 = req0_valid;
    gnt1 = req1_valid;
    if (req0_valid && req1_valid) begin
      gnt0 = ~prio;
      gnt1 = prio;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp_valid  = 1'b0;
    accept     = 1'b0;
    rsp_hs     = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = gnt0;
        req1_ready = gnt1;
        accept     = gnt0 | gnt1;
        if (accept) state_nxt = WAIT;
      end
      WAIT: begin
        if (cnt == '0) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_hs    = rsp_ready;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign dp_sel = 1'b0;

  // Operands are held from accept until the next accept, so the datapath sees stable inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_id    <= 1'b0;
      rsp_z     <= '0;
      rsp_carry <= 1'b0;
      rsp_ovf   <= 1'b0;
      dp_a      <= '0;
      dp_b      <= '0;
      dp_addsub <= 1'b0;
      cnt       <= '0;
    end else begin
      if (accept) begin
        rsp_id    <= gnt1;
        dp_a      <= gnt1 ? (req1_acc ? shadow1 : req1_a) : (req0_acc ? shadow0 : req0_a);
        dp_b      <= gnt1 ? req1_b : req0_b;
        dp_addsub <= gnt1 ? req1_sub : req0_sub;
        cnt       <= CW'(DP_LAT);
      end else if (state == WAIT) begin
        if (cnt == '0) begin
          rsp_z     <= dp_z;
          rsp_carry <= dp_carry;
          rsp_ovf   <= dp_ovf;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

  // Clear is written last so it overrides a coincident result write-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio    <= 1'b0;
      shadow0 <= '0;
      shadow1 <= '0;
    end else begin
      if (rsp_hs) begin
        prio <= ~rsp_id;
        if (rsp_id) shadow1 <= rsp_z;
        else        shadow0 <= rsp_z;
      end
      if (acc_clr[0]) shadow0 <= '0;
      if (acc_clr[1]) shadow1 <= '0;
    end
  end

endmodule

// File: tb/tb_add_sub_arbiter.sv
// tb/tb_add_sub_arbiter.sv - directed self-checking bench for add_sub_arbiter
// Includes a one-stage registered add/sub datapath model feeding the arbiter.
module tb_add_sub_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_ready, req0_sub, req0_acc;
  logic       req1_valid, req1_ready, req1_sub, req1_acc;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0] acc_clr;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_ovf;
  logic [7:0] rsp_z;
  logic [7:0] dp_a, dp_b, dp_z;
  logic       dp_sel, dp_addsub, dp_carry, dp_ovf;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  add_sub_arbiter #(.WIDTH(8), .DP_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_sub(req0_sub), .req0_acc(req0_acc),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_sub(req1_sub), .req1_acc(req1_acc),
    .acc_clr(acc_clr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_z(rsp_z),
    .rsp_carry(rsp_carry), .rsp_ovf(rsp_ovf),
    .dp_a(dp_a), .dp_b(dp_b), .dp_sel(dp_sel), .dp_addsub(dp_addsub),
    .dp_z(dp_z), .dp_carry(dp_carry), .dp_ovf(dp_ovf)
  );

  // Shared datapath: carry is the raw carry-out of a + b or a + ~b + 1.
  logic [8:0] dp_sum;
  logic       dp_bx, dp_ov;
  assign dp_sum = dp_addsub ? ({1'b0, dp_a} + {1'b0, ~dp_b} + 9'd1) : ({1'b0, dp_a} + {1'b0, dp_b});
  assign dp_bx  = dp_addsub ? ~dp_b[7] : dp_b[7];
  assign dp_ov  = (dp_a[7] == dp_bx) && (dp_sum[7] != dp_a[7]);
  always @(posedge clk) begin
    dp_z     <= dp_sum[7:0];
    dp_carry <= dp_sum[8];
    dp_ovf   <= dp_ov;
  end

  task automatic drive_req(input bit n, input logic v, input logic [7:0] a, input logic [7:0] b,
                           input logic sub, input logic acc);
    if (n) begin
      req1_valid = v; req1_a = a; req1_b = b; req1_sub = sub; req1_acc = acc;
    end else begin
      req0_valid = v; req0_a = a; req0_b = b; req0_sub = sub; req0_acc = acc;
    end
  endtask

  // Runs one command to completion with rsp_ready high; returns observations, lat=-1 on timeout.
  task automatic do_op(input bit n, input logic [7:0] a, input logic [7:0] b, input logic sub,
                       input logic acc, output logic [7:0] z, output logic c, output logic o,
                       output logic id, output logic [7:0] da, output int lat);
    int t;
    z = 'x; c = 1'bx; o = 1'bx; id = 1'bx; da = 'x; lat = -1;
    drive_req(n, 1'b1, a, b, sub, acc);
    #1;
    t = 0;
    while ((n ? req1_ready : req0_ready) !== 1'b1 && t < 20) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 20) begin
      drive_req(n, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
      return;
    end
    @(posedge clk); #1;
    drive_req(n, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    da = dp_a;
    t = 0;
    while (rsp_valid !== 1'b1 && t < 20) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 20) return;
    lat = t; z = rsp_z; c = rsp_carry; o = rsp_ovf; id = rsp_id;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b1; rsp_ready = 1'b1; acc_clr = 2'b00;
    drive_req(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    drive_req(1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    #23 rst_n = 1'b0;
    #1;
    checks++;
    if ({rsp_valid, rsp_id, rsp_z, rsp_carry, rsp_ovf} !== 11'd0) begin
      failures++; $display("FAIL reset_rsp got=%b exp=0", {rsp_valid, rsp_id, rsp_z, rsp_carry, rsp_ovf});
    end
    checks++;
    if ({dp_a, dp_b, dp_sel, dp_addsub} !== 18'd0) begin
      failures++; $display("FAIL reset_dp got=%b exp=0", {dp_a, dp_b, dp_sel, dp_addsub});
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      failures++; $display("FAIL reset_ready got=%b exp=00", {req0_ready, req1_ready});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic_add;
    logic [7:0] z, da; logic c, o, id; int lat;
    do_op(1'b0, 8'd25, 8'd10, 1'b0, 1'b0, z, c, o, id, da, lat);
    checks++; if (lat !== 2)      begin failures++; $display("FAIL basic_lat got=%0d exp=2", lat); end
    checks++; if (id !== 1'b0)    begin failures++; $display("FAIL basic_id got=%b exp=0", id); end
    checks++; if (z !== 8'd35)    begin failures++; $display("FAIL basic_z got=%0d exp=35", z); end
    checks++; if ({c, o} !== 2'b00) begin failures++; $display("FAIL basic_flags got=%b exp=00", {c, o}); end
    checks++; if (da !== 8'd25)   begin failures++; $display("FAIL basic_dp_a got=%0d exp=25", da); end
    checks++; if (dp_sel !== 1'b0) begin failures++; $display("FAIL basic_dp_sel got=%b exp=0", dp_sel); end
    do_op(1'b0, 8'd99, 8'd0, 1'b0, 1'b1, z, c, o, id, da, lat);
    checks++; if (z !== 8'd35)    begin failures++; $display("FAIL basic_shadow0 got=%0d exp=35", z); end
  endtask

  task automatic test_priority;
    int t, gid, errs;
    logic [7:0] z; logic id;
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    drive_req(1'b0, 1'b1, 8'd25, 8'd10, 1'b0, 1'b0);
    drive_req(1'b1, 1'b1, 8'd40, 8'd15, 1'b1, 1'b0);
    #1;
    for (int g = 0; g < 4; g++) begin
      t = 0;
      while (req0_ready !== 1'b1 && req1_ready !== 1'b1 && t < 20) begin
        @(posedge clk); #1; t++;
      end
      checks++;
      if ((req0_ready & req1_ready) !== 1'b0 || t >= 20) begin
        failures++; $display("FAIL prio_ready[%0d] got=%b%b exp=one-hot", g, req0_ready, req1_ready);
      end
      gid = (req1_ready === 1'b1) ? 1 : 0;
      @(posedge clk); #1;
      t = 0;
      while (rsp_valid !== 1'b1 && t < 20) begin
        @(posedge clk); #1; t++;
      end
      id = rsp_id; z = rsp_z;
      @(posedge clk); #1;
      errs = 0;
      checks++;
      if (gid != g % 2) begin failures++; $display("FAIL prio_grant[%0d] got=%0d exp=%0d", g, gid, g % 2); end
      checks++;
      if (id !== 1'(g % 2)) begin failures++; $display("FAIL prio_id[%0d] got=%b exp=%0d", g, id, g % 2); end
      checks++;
      if (z !== ((g % 2) ? 8'd25 : 8'd35)) begin
        failures++; $display("FAIL prio_z[%0d] got=%0d exp=%0d", g, z, (g % 2) ? 25 : 35);
      end
    end
    drive_req(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    drive_req(1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
  endtask

  task automatic test_accumulate;
    logic [7:0] z, da; logic c, o, id; int lat;
    do_op(1'b1, 8'd99, 8'd5, 1'b0, 1'b1, z, c, o, id, da, lat);
    checks++; if (z !== 8'd30)  begin failures++; $display("FAIL acc_add z got=%0d exp=30", z); end
    checks++; if (da !== 8'd25) begin failures++; $display("FAIL acc_add dp_a got=%0d exp=25", da); end
    checks++; if (id !== 1'b1)  begin failures++; $display("FAIL acc_add id got=%b exp=1", id); end
    do_op(1'b1, 8'd99, 8'd3, 1'b1, 1'b1, z, c, o, id, da, lat);
    checks++; if (z !== 8'd27)  begin failures++; $display("FAIL acc_sub z got=%0d exp=27", z); end
    do_op(1'b0, 8'd99, 8'd0, 1'b0, 1'b1, z, c, o, id, da, lat);
    checks++; if (z !== 8'd35)  begin failures++; $display("FAIL acc_shadow0 z got=%0d exp=35", z); end
    acc_clr = 2'b10;
    @(posedge clk); #1;
    acc_clr = 2'b00;
    do_op(1'b1, 8'd99, 8'd7, 1'b0, 1'b1, z, c, o, id, da, lat);
    checks++; if (z !== 8'd7)   begin failures++; $display("FAIL acc_clr1 z got=%0d exp=7", z); end
    do_op(1'b0, 8'd99, 8'd0, 1'b0, 1'b1, z, c, o, id, da, lat);
    checks++; if (z !== 8'd35)  begin failures++; $display("FAIL acc_clr_keep0 z got=%0d exp=35", z); end
  endtask

  task automatic test_flags;
    logic [7:0] z, da; logic c, o, id; int lat;
    do_op(1'b0, 8'd100, 8'd100, 1'b0, 1'b0, z, c, o, id, da, lat);
    checks++; if ({z, c, o} !== {8'd200, 1'b0, 1'b1}) begin
      failures++; $display("FAIL flags_ovf got z=%0d c=%b o=%b exp z=200 c=0 o=1", z, c, o);
    end
    do_op(1'b0, 8'd200, 8'd100, 1'b0, 1'b0, z, c, o, id, da, lat);
    checks++; if ({z, c, o} !== {8'd44, 1'b1, 1'b0}) begin
      failures++; $display("FAIL flags_carry got z=%0d c=%b o=%b exp z=44 c=1 o=0", z, c, o);
    end
    do_op(1'b1, 8'd5, 8'd10, 1'b1, 1'b0, z, c, o, id, da, lat);
    checks++; if ({z, c, o} !== {8'd251, 1'b0, 1'b0}) begin
      failures++; $display("FAIL flags_borrow got z=%0d c=%b o=%b exp z=251 c=0 o=0", z, c, o);
    end
  endtask

  task automatic test_backpressure;
    int t, bad;
    rsp_ready = 1'b0;
    drive_req(1'b0, 1'b1, 8'd7, 8'd1, 1'b0, 1'b0);
    #1;
    t = 0;
    while (req0_ready !== 1'b1 && t < 20) begin @(posedge clk); #1; t++; end
    @(posedge clk); #1;
    drive_req(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    drive_req(1'b1, 1'b1, 8'd1, 8'd1, 1'b0, 1'b0);
    t = 0;
    while (rsp_valid !== 1'b1 && t < 20) begin @(posedge clk); #1; t++; end
    bad = 0;
    repeat (5) begin
      if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_z !== 8'd8 || rsp_carry !== 1'b0 ||
          rsp_ovf !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL bp_hold bad_cycles got=%0d exp=0", bad); end
    drive_req(1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL bp_release rsp_valid got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_reset_mid_wait;
    int t, seen;
    logic [7:0] z, da; logic c, o, id; int lat;
    drive_req(1'b0, 1'b1, 8'd50, 8'd1, 1'b0, 1'b0);
    #1;
    t = 0;
    while (req0_ready !== 1'b1 && t < 20) begin @(posedge clk); #1; t++; end
    @(posedge clk); #1;
    drive_req(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({rsp_valid, dp_a, dp_b, dp_addsub} !== 18'd0) begin
      failures++; $display("FAIL rstwait_async got=%b exp=0", {rsp_valid, dp_a, dp_b, dp_addsub});
    end
    #2 rst_n = 1'b1;
    seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b0) seen++;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL rstwait_no_rsp got=%0d exp=0", seen); end
    do_op(1'b0, 8'd99, 8'd3, 1'b0, 1'b1, z, c, o, id, da, lat);
    checks++; if (z !== 8'd3)  begin failures++; $display("FAIL rstwait_shadow z got=%0d exp=3", z); end
    checks++; if (lat !== 2)   begin failures++; $display("FAIL rstwait_lat got=%0d exp=2", lat); end
  endtask

  initial begin
    test_reset;
    test_basic_add;
    test_priority;
    test_accumulate;
    test_flags;
    test_backpressure;
    test_reset_mid_wait;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/add_sub_arbiter.md
ADD_SUB_ARBITER -- requirements
Module: add_sub_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width.
REQ-002 Parameter DP_LAT, default 1, datapath clock edges from operands driven to registered result valid.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 req0_valid / req1_valid  in  1  requester N has a command.
REQ-006 req0_ready / req1_ready  out  1  command accepted on valid&ready at rising edge.
REQ-007 req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands.
REQ-008 req0_sub / req1_sub  in  1  0=add, 1=subtract (A-B).
REQ-009 req0_acc / req1_acc  in  1  1=use requester's shadow accumulator as A, ignore reqN_a.
REQ-010 acc_clr  in  2  bit N clears requester N shadow accumulator.
REQ-011 rsp_valid  out  1  result available; rsp_ready  in  1  consumer accepts.
REQ-012 rsp_id  out  1; rsp_z  out  WIDTH; rsp_carry  out  1; rsp_ovf  out  1.
REQ-013 dp_a, dp_b  out  WIDTH; dp_sel  out  1; dp_addsub  out  1  drive shared add/sub datapath.
REQ-014 dp_z  in  WIDTH; dp_carry  in  1; dp_ovf  in  1  datapath registered results.

Function
REQ-015 FSM states IDLE, WAIT, RESP; reset state IDLE.
REQ-016 IDLE grant: only one valid -> that requester; both valid -> requester named by priority pointer prio; none -> no grant.
REQ-017 reqN_ready = (state==IDLE) & granted N; never both high; low in WAIT and RESP.
REQ-018 On accept: latch id, dp_a = (acc ? shadow[id] : a), dp_b = b, dp_addsub = sub; dp_sel always 0; go WAIT; load counter with DP_LAT.
REQ-019 dp_a/dp_b/dp_addsub registered, held stable from accept edge until return to IDLE.
REQ-020 WAIT: counter decrements each edge; at the edge where counter==0 capture dp_z/dp_carry/dp_ovf into rsp_z/rsp_carry/rsp_ovf, go RESP; rsp_valid high starting DP_LAT+1 cycles after the accept edge.
REQ-021 RESP: rsp_valid=1, rsp_id/rsp_z/rsp_carry/rsp_ovf stable until rsp_valid&rsp_ready edge.
REQ-022 On response handshake: shadow[rsp_id] <= rsp_z; prio <= ~rsp_id; go IDLE; next accept possible same cycle as return only on following edge (one IDLE cycle minimum).
REQ-023 rsp_valid low whenever state != RESP.
REQ-024 acc_clr[N] clears shadow[N] on any edge; if coincident with update of shadow[N], clear wins; clear of other requester unaffected.
REQ-025 Arithmetic is WIDTH-bit wrap-around; carry/overflow reported exactly as returned by datapath, no recomputation.
REQ-026 Commands and acc_clr inputs are sampled only at rising edges; reqN_valid dropping while not granted has no effect.

Reset
REQ-027 rst_n low asynchronously forces: state IDLE, prio 0, shadow[0]=shadow[1]=0, rsp_valid 0, rsp_id/rsp_z/rsp_carry/rsp_ovf 0, dp_a/dp_b/dp_sel/dp_addsub 0, counter 0.
REQ-028 Reset asserted mid-WAIT or mid-RESP abandons the operation; no response issued; shadow not updated.
REQ-029 First grant after reset with both requesters valid goes to requester 0.

Verification
REQ-030 Reset: assert rst_n=0 off-clock -> all outputs 0 immediately; release, no valid -> both ready 0.
REQ-031 req0 a=25 b=10 add, rsp_ready=1 -> rsp_valid 2 cycles after accept, rsp_id=0, z=35, carry=0, ovf=0; shadow[0]=35.
REQ-032 Both valid after reset, req0 25+10, req1 40-15 -> req0 served first (z=35), then req1 (z=25, id=1); with both held valid, grants alternate 0,1,0,1.
REQ-033 Accumulate: after REQ-032, req1 acc=1 b=5 add -> z=30; req1 acc=1 b=3 sub -> z=27; shadow[0] still 35; acc_clr=2'b10 then req1 acc add b=7 -> z=7.
REQ-034 Flags: 100+100 -> z=200, ovf=1, carry=0; 200+100 -> z=44, carry=1; 5-10 -> z=251, carry per datapath, ovf=0.
REQ-035 Backpressure/reset: rsp_ready=0 for 5 cycles -> rsp fields stable, both ready 0; rst_n pulse during WAIT -> no rsp_valid, shadow unchanged, next accept works.
